// File: rtl/shreg_tap_delay_if.sv
// Tap-delay line bus: shift control and serial input toward the line,
// tap/last-stage data and fill status back from it.
interface shreg_tap_delay_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 130
);
  localparam int AW = $clog2(DEPTH);

  logic             ce;
  logic [WIDTH-1:0] i;
  logic [AW-1:0]    a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qf;
  logic             vld;
  logic             full;

  modport master (
    output ce, i, a,
    input  q, qf, vld, full
  );

  modport slave (
    input  ce, i, a,
    output q, qf, vld, full
  );
endinterface

// File: rtl/shreg_tap_delay.sv
// Multi-lane addressable shift-register delay line with clock enable,
// asynchronous active-low clear, selectable clock edge and fill tracking.
module shreg_tap_delay #(
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 130,
  parameter bit NEG_CLK  = 1'b1,
  parameter bit INIT_ALT = 1'b1
) (
  input logic              clk,
  input logic              rn,
  shreg_tap_delay_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  typedef logic [WIDTH-1:0][DEPTH-1:0] stage_t;
  typedef logic [FW-1:0]               fill_t;

  localparam fill_t FILL_MAX = fill_t'(DEPTH);

  function automatic stage_t power_up_pattern();
    stage_t p;
    for (int w = 0; w < WIDTH; w++) begin
      for (int d = 0; d < DEPTH; d++) begin
        p[w][d] = INIT_ALT && (((d + w) % 2) == 0);
      end
    end
    return p;
  endfunction

  // Power-up contents only; a reset clears to zero and never restores this.
  stage_t stg  = power_up_pattern();
  fill_t  fill = '0;

  stage_t stg_shift;
  fill_t  fill_inc;

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    stg_shift = stg;
    fill_inc  = fill;
    for (int w = 0; w < WIDTH; w++) begin
      stg_shift[w] = {stg[w][DEPTH-2:0], bus.i[w]};
    end
    if (fill != FILL_MAX) begin
      fill_inc = fill + fill_t'(1);
    end
  end

  // Only one of these branches elaborates, so the state has a single driver.
  if (NEG_CLK) begin : g_neg
    always_ff @(negedge clk or negedge rn) begin
      // NOTE: the whole array is cleared on reset, which keeps it out of SRL primitives.
      if (!rn) begin
        stg  <= '0;
        fill <= '0;
      end else if (bus.ce) begin
        // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
        stg  <= stg_shift;
        fill <= fill_inc;
      end
    end
  end else begin : g_pos
    always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
        stg  <= '0;
        fill <= '0;
      end else if (bus.ce) begin
        stg  <= stg_shift;
        fill <= fill_inc;
      end
    end
  end

  logic [AW-1:0]    tap;
  logic             tap_in_range;
  logic [WIDTH-1:0] q_tap;
  logic [WIDTH-1:0] q_last;

  assign tap          = bus.a;
  assign tap_in_range = 32'(tap) < 32'(DEPTH);

  // Combinational read: q and vld follow the tap address within the cycle.
  always_comb begin
    q_tap  = '0;
    q_last = '0;
    for (int w = 0; w < WIDTH; w++) begin
      q_last[w] = stg[w][DEPTH-1];
      if (tap_in_range) begin
        q_tap[w] = stg[w][tap];
      end
    end
  end

  assign bus.q    = q_tap;
  assign bus.qf   = q_last;
  assign bus.vld  = tap_in_range && (32'(fill) > 32'(tap));
  assign bus.full = (fill == FILL_MAX);
endmodule
